// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed 4-digit hexadecimal seven-segment scan driver.
// Each digit owns one slot of REFRESH_DIV cycles. The first BLANK_CYCLES of a
// slot keep every anode dark so the previous digit's pattern cannot ghost.
// The displayed word is captured only at the start of a digit-0 slot, so a
// full scan always shows one coherent snapshot.
module seven_seg_scan_driver #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic        qzt_clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        hold,
  input  logic [3:0]  digit_enable,
  input  logic        lz_blank,
  input  logic [3:0]  dp_in,
  output logic [3:0]  anode,
  output logic [6:0]  segments,
  output logic        dp,
  output logic        scan_tick
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic POL = ACTIVE_LOW;

  // Slot position of the edge about to happen, and the digit that slot serves.
  logic [CW-1:0] r_slotCnt;
  logic [1:0]    r_digit;

  // Scan-stable copies of the display inputs.
  logic [15:0]   r_snap;
  logic [3:0]    r_enable;
  logic          r_lz;
  logic [3:0]    r_dpReq;

  // Registered outputs.
  logic [3:0]    r_anode;
  logic [6:0]    r_segments;
  logic          r_dp;
  logic          r_scanTick;

  logic          w_slotStart;
  logic          w_slotEnd;
  logic          w_driveWindow;
  logic [15:0]   w_snap;
  logic [3:0]    w_enable;
  logic          w_lz;
  logic [3:0]    w_dpReq;
  logic [3:0]    w_nibble;
  logic          w_lzSuppress;
  logic          w_lit;
  logic [6:0]    w_code;
  logic [3:0]    w_anodeHigh;
  logic [6:0]    w_segHigh;
  logic          w_dpHigh;

  assign w_slotStart   = (r_slotCnt == '0);
  assign w_slotEnd     = (r_slotCnt == CW'(REFRESH_DIV - 1));
  assign w_driveWindow = (r_slotCnt >= CW'(BLANK_CYCLES));

  // On a slot-start edge the freshly sampled values must already steer the
  // outputs, which matters when BLANK_CYCLES is zero.
  assign w_snap   = (w_slotStart && (r_digit == 2'd0) && !hold) ? value : r_snap;
  assign w_enable = w_slotStart ? digit_enable : r_enable;
  assign w_lz     = w_slotStart ? lz_blank     : r_lz;
  assign w_dpReq  = w_slotStart ? dp_in        : r_dpReq;

  // Pick the snapshot nibble for the current digit and decide whether leading-zero
  // blanking hides it; digit 0 is always shown so a zero word still reads "0".
  always_comb begin
    w_nibble     = w_snap[3:0];
    w_lzSuppress = 1'b0;
    case (r_digit)
      2'd0: begin
        w_nibble     = w_snap[3:0];
        w_lzSuppress = 1'b0;
      end
      2'd1: begin
        w_nibble     = w_snap[7:4];
        w_lzSuppress = w_lz && (w_snap[15:4] == 12'h000);
      end
      2'd2: begin
        w_nibble     = w_snap[11:8];
        w_lzSuppress = w_lz && (w_snap[15:8] == 8'h00);
      end
      default: begin
        w_nibble     = w_snap[15:12];
        w_lzSuppress = w_lz && (w_snap[15:12] == 4'h0);
      end
    endcase
  end

  // Hex to active-high g..a segment pattern.
  always_comb begin
    w_code = 7'h00;
    case (w_nibble)
      4'h0: w_code = 7'h3F;
      4'h1: w_code = 7'h06;
      4'h2: w_code = 7'h5B;
      4'h3: w_code = 7'h4F;
      4'h4: w_code = 7'h66;
      4'h5: w_code = 7'h6D;
      4'h6: w_code = 7'h7D;
      4'h7: w_code = 7'h07;
      4'h8: w_code = 7'h7F;
      4'h9: w_code = 7'h6F;
      4'hA: w_code = 7'h77;
      4'hB: w_code = 7'h7C;
      4'hC: w_code = 7'h39;
      4'hD: w_code = 7'h5E;
      4'hE: w_code = 7'h79;
      default: w_code = 7'h71;
    endcase
  end

  // Segments and dp follow the anode: nothing is driven while the digit is dark.
  assign w_lit       = w_driveWindow && w_enable[r_digit] && !w_lzSuppress;
  assign w_anodeHigh = w_lit ? (4'b0001 << r_digit) : 4'b0000;
  assign w_segHigh   = w_lit ? w_code : 7'h00;
  assign w_dpHigh    = w_lit && w_dpReq[r_digit];

  // Slot counter and digit index; the digit advances on the last edge of a slot.
  always_ff @(posedge qzt_clk) begin
    if (reset) begin
      r_slotCnt <= '0;
      r_digit   <= 2'd0;
    end else begin
      r_slotCnt <= w_slotEnd ? '0 : (r_slotCnt + CW'(1));
      r_digit   <= w_slotEnd ? (r_digit + 2'd1) : r_digit;
    end
  end

  // Snapshot and per-slot sampled controls.
  always_ff @(posedge qzt_clk) begin
    if (reset) begin
      r_snap   <= 16'h0000;
      r_enable <= 4'h0;
      r_lz     <= 1'b0;
      r_dpReq  <= 4'h0;
    end else begin
      r_snap   <= w_snap;
      r_enable <= w_enable;
      r_lz     <= w_lz;
      r_dpReq  <= w_dpReq;
    end
  end

  // Output registers, converted to the board's polarity.
  always_ff @(posedge qzt_clk) begin
    if (reset) begin
      r_anode    <= {4{POL}};
      r_segments <= {7{POL}};
      r_dp       <= POL;
      r_scanTick <= 1'b0;
    end else begin
      r_anode    <= w_anodeHigh ^ {4{POL}};
      r_segments <= w_segHigh ^ {7{POL}};
      r_dp       <= w_dpHigh ^ POL;
      r_scanTick <= w_slotStart;
    end
  end

  assign anode     = r_anode;
  assign segments  = r_segments;
  assign dp        = r_dp;
  assign scan_tick = r_scanTick;

endmodule
